// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared arbiter state encoding and burst geometry defaults
// for the SDRAM port arbiter.
package sdram_arb_pkg;

   localparam int unsigned ARB_BURST_LEN   = 512;
   localparam int unsigned ARB_FRAME_WORDS = 307200;
   localparam int unsigned ARB_STATE_W     = 2;

   typedef enum logic [ARB_STATE_W-1:0] {
      ARB_IDLE = 2'd0,
      ARB_WR   = 2'd1,
      ARB_RD   = 2'd2
   } arb_state_t;

endpackage : sdram_arb_pkg

// File: rtl/sdram_port_arb_if.sv
// sdram_port_arb_if: burst request/ack handshake and base addresses
// between the port arbiter (master) and the SDRAM controller (slave).
interface sdram_port_arb_if #(
   parameter int unsigned ADDR_W = 22
);

   logic              wr_sdram_req;
   logic              wr_sdram_ack;
   logic              rd_sdram_req;
   logic              rd_sdram_ack;
   logic [ADDR_W-1:0] wr_base_addr;
   logic [ADDR_W-1:0] rd_base_addr;

   modport master (
      output wr_sdram_req,
      output rd_sdram_req,
      output wr_base_addr,
      output rd_base_addr,
      input  wr_sdram_ack,
      input  rd_sdram_ack
   );

   modport slave (
      input  wr_sdram_req,
      input  rd_sdram_req,
      input  wr_base_addr,
      input  rd_base_addr,
      output wr_sdram_ack,
      output rd_sdram_ack
   );

endinterface : sdram_port_arb_if

// File: rtl/sdram_port_arb_burst_addr_gen.sv
// burst_addr_gen: burst base address for one direction. Advances by
// BURST_LEN on each step pulse and wraps to 0 at the end of the frame.
// wrap_c flags the step that performs the wrap.
module burst_addr_gen #(
   parameter int unsigned ADDR_W      = 22,
   parameter int unsigned BURST_LEN   = 512,
   parameter int unsigned FRAME_WORDS = 307200
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              step,
   output logic [ADDR_W-1:0] base_addr,
   output logic              wrap_c
);

   localparam int unsigned SUM_W = ADDR_W + 1;

   logic [SUM_W-1:0] sum_c;

   // One extra bit so the frame-end sum never aliases.
   assign sum_c  = SUM_W'(base_addr) + SUM_W'(BURST_LEN);
   assign wrap_c = step && (sum_c == SUM_W'(FRAME_WORDS));

   // Address register: only moves on a step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_addr <= '0;
      end else if (step) begin
         base_addr <= wrap_c ? '0 : ADDR_W'(sum_c);
      end
   end

endmodule : burst_addr_gen

// File: rtl/sdram_port_arb.sv
// sdram_port_arb: requester side of the SDRAM burst req/ack handshake.
// Watches the write FIFO (image source) and read FIFO (VGA sink), raises one
// burst request at a time, holds it until ack and tracks per-direction
// burst base addresses that wrap once per frame.
// Optional macro ARB_RR_EN: round-robin between write and read when both
// want service; otherwise read always wins.
module sdram_port_arb
   import sdram_arb_pkg::*;
#(
   parameter int unsigned BURST_LEN   = ARB_BURST_LEN,
   parameter int unsigned FIFO_W      = 10,
   parameter int unsigned RD_FIFO_DEP = 1024,
   parameter int unsigned ADDR_W      = 22,
   parameter int unsigned FRAME_WORDS = ARB_FRAME_WORDS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_done,
   input  logic [FIFO_W-1:0] wr_fifo_level,
   input  logic [FIFO_W-1:0] rd_fifo_level,
   sdram_port_arb_if.master  sdram,
   output logic              frame_valid,
   output logic              wr_frame_done
);

   // One bit of headroom so a threshold equal to the FIFO depth still fits.
   localparam int unsigned      LVL_W     = FIFO_W + 1;
   localparam logic [LVL_W-1:0] WR_THRESH = LVL_W'(BURST_LEN);
   localparam logic [LVL_W-1:0] RD_THRESH = LVL_W'(RD_FIFO_DEP - BURST_LEN);

   arb_state_t        state;
   logic              wr_req;
   logic              rd_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;

   logic wr_need_c;
   logic rd_need_c;
   logic grant_rd_c;
   logic grant_wr_c;
   logic wr_step_c;
   logic rd_step_c;
   logic wr_wrap_c;
   logic unused_rd_wrap_c;

   // Service demand from each FIFO.
   assign wr_need_c = (LVL_W'(wr_fifo_level) >= WR_THRESH);
   assign rd_need_c = frame_valid && (LVL_W'(rd_fifo_level) <= RD_THRESH);

`ifdef ARB_RR_EN
   logic rr_last;

   // On contention grant the direction not served last (0=write, 1=read).
   assign grant_rd_c = rd_need_c && !(wr_need_c && rr_last);
`else
   // Read wins on contention: a starved VGA read FIFO is unrecoverable.
   assign grant_rd_c = rd_need_c;
`endif
   assign grant_wr_c = wr_need_c && !grant_rd_c;

   // Only the ack matching the active direction moves an address.
   assign wr_step_c = (state == ARB_WR) && sdram.wr_sdram_ack;
   assign rd_step_c = (state == ARB_RD) && sdram.rd_sdram_ack;

   // Arbiter FSM with registered requests; ack returns to IDLE, which
   // guarantees at least one idle cycle before the next request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ARB_IDLE;
         wr_req <= 1'b0;
         rd_req <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (init_done && grant_rd_c) begin
                  state  <= ARB_RD;
                  rd_req <= 1'b1;
               end else if (init_done && grant_wr_c) begin
                  state  <= ARB_WR;
                  wr_req <= 1'b1;
               end
            end
            ARB_WR: begin
               if (sdram.wr_sdram_ack) begin
                  state  <= ARB_IDLE;
                  wr_req <= 1'b0;
               end
            end
            ARB_RD: begin
               if (sdram.rd_sdram_ack) begin
                  state  <= ARB_IDLE;
                  rd_req <= 1'b0;
               end
            end
            default: begin
               state  <= ARB_IDLE;
               wr_req <= 1'b0;
               rd_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef ARB_RR_EN
   // Remember the direction of every grant for round-robin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last <= 1'b0;
      end else if ((state == ARB_IDLE) && init_done && (grant_rd_c || grant_wr_c)) begin
         rr_last <= grant_rd_c;
      end
   end
`endif

   // Frame tracking: pulse on write wrap, frame_valid sticks until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_frame_done <= 1'b0;
         frame_valid   <= 1'b0;
      end else begin
         wr_frame_done <= wr_wrap_c;
         frame_valid   <= frame_valid | wr_wrap_c;
      end
   end

   burst_addr_gen #(
      .ADDR_W      (ADDR_W),
      .BURST_LEN   (BURST_LEN),
      .FRAME_WORDS (FRAME_WORDS)
   ) u_wr_addr (
      .clk       (clk),
      .rst_n     (rst_n),
      .step      (wr_step_c),
      .base_addr (wr_addr),
      .wrap_c    (wr_wrap_c)
   );

   burst_addr_gen #(
      .ADDR_W      (ADDR_W),
      .BURST_LEN   (BURST_LEN),
      .FRAME_WORDS (FRAME_WORDS)
   ) u_rd_addr (
      .clk       (clk),
      .rst_n     (rst_n),
      .step      (rd_step_c),
      .base_addr (rd_addr),
      .wrap_c    (unused_rd_wrap_c)
   );

   assign sdram.wr_sdram_req = wr_req;
   assign sdram.rd_sdram_req = rd_req;
   assign sdram.wr_base_addr = wr_addr;
   assign sdram.rd_base_addr = rd_addr;

endmodule : sdram_port_arb

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb: directed checks of the SDRAM port arbiter.
module tb_sdram_port_arb;

   localparam int unsigned FIFO_W = 10;
   localparam int unsigned ADDR_W = 22;
   localparam int unsigned BLEN   = 512;
   localparam int unsigned FRAME  = 307200;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              init_done = 1'b0;
   logic [FIFO_W-1:0] wr_lvl    = '0;
   logic [FIFO_W-1:0] rd_lvl    = '0;
   logic              frame_valid;
   logic              wr_frame_done;

   int n_checks = 0;
   int n_fail   = 0;
   int fd_count = 0;
   int both_hi  = 0;

   sdram_port_arb_if #(.ADDR_W(ADDR_W)) bus ();

   sdram_port_arb #(
      .BURST_LEN   (BLEN),
      .FIFO_W      (FIFO_W),
      .RD_FIFO_DEP (1024),
      .ADDR_W      (ADDR_W),
      .FRAME_WORDS (FRAME)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .init_done     (init_done),
      .wr_fifo_level (wr_lvl),
      .rd_fifo_level (rd_lvl),
      .sdram         (bus),
      .frame_valid   (frame_valid),
      .wr_frame_done (wr_frame_done)
   );

   always #5 clk = ~clk;

   // Background monitors: frame-done pulses and request exclusivity.
   always @(negedge clk) begin
      if (wr_frame_done) fd_count++;
      if (bus.wr_sdram_req && bus.rd_sdram_req) both_hi++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input bit rd, input int max_cyc, input string tag);
      int n = 0;
      while (!(rd ? bus.rd_sdram_req : bus.wr_sdram_req) && n < max_cyc) begin
         step();
         n++;
      end
      check(tag, 32'(rd ? bus.rd_sdram_req : bus.wr_sdram_req), 32'd1);
   endtask

   task automatic pulse_ack(input bit wr, input bit rd);
      bus.wr_sdram_ack = wr;
      bus.rd_sdram_ack = rd;
      step();
      bus.wr_sdram_ack = 1'b0;
      bus.rd_sdram_ack = 1'b0;
   endtask

   initial begin
      int req_seen;
      bus.wr_sdram_ack = 1'b0;
      bus.rd_sdram_ack = 1'b0;
      wr_lvl = 10'd600;
      rd_lvl = 10'd1000;

      // Reset values
      #1;
      step();
      check("rst_wr_req", 32'(bus.wr_sdram_req), 32'd0);
      check("rst_rd_req", 32'(bus.rd_sdram_req), 32'd0);
      check("rst_wr_addr", 32'(bus.wr_base_addr), 32'd0);
      check("rst_rd_addr", 32'(bus.rd_base_addr), 32'd0);
      check("rst_fvalid", 32'(frame_valid), 32'd0);
      check("rst_fdone", 32'(wr_frame_done), 32'd0);
      rst_n = 1'b1;

      // 1: no request before init_done
      req_seen = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (bus.wr_sdram_req || bus.rd_sdram_req) req_seen++;
      end
      check("t1_no_req_wo_init", 32'(req_seen), 32'd0);

      // 2: first write burst
      init_done = 1'b1;
      wr_lvl    = 10'd512;
      wait_req(1'b0, 2, "t2_wr_req_by_c2");
      check("t2_no_rd_req", 32'(bus.rd_sdram_req), 32'd0);
      check("t2_wr_addr_hold", 32'(bus.wr_base_addr), 32'd0);
      pulse_ack(1'b1, 1'b0);
      check("t2_req_drop", 32'(bus.wr_sdram_req), 32'd0);
      check("t2_addr_512", 32'(bus.wr_base_addr), 32'd512);

      // 5: stray read ack while writing
      wait_req(1'b0, 4, "t5_wr_req");
      pulse_ack(1'b0, 1'b1);
      check("t5_rd_addr_same", 32'(bus.rd_base_addr), 32'd0);
      check("t5_wr_req_held", 32'(bus.wr_sdram_req), 32'd1);
      check("t5_wr_addr_same", 32'(bus.wr_base_addr), 32'd512);

      // 3: remaining bursts of the first frame
      for (int i = 2; i <= 600; i++) begin
         wait_req(1'b0, 4, "t3_wr_req");
         if (i == 600) wr_lvl = '0;
         if (i == 599) check("t3_fvalid_early", 32'(frame_valid), 32'd0);
         pulse_ack(1'b1, 1'b0);
         check("t3_wr_addr", 32'(bus.wr_base_addr), (32'(i) * 32'(BLEN)) % 32'(FRAME));
      end
      check("t3_fdone_pulse", 32'(wr_frame_done), 32'd1);
      check("t3_fvalid_set", 32'(frame_valid), 32'd1);
      step();
      check("t3_fdone_single", 32'(wr_frame_done), 32'd0);
      check("t3_fdone_count", 32'(fd_count), 32'd1);
      check("t3_fvalid_sticky", 32'(frame_valid), 32'd1);

      // 4: contention with both needs
      wr_lvl = 10'd512;
      rd_lvl = 10'd100;
      step();
      check("t4_rd_first", 32'(bus.rd_sdram_req), 32'd1);
      check("t4_wr_not_first", 32'(bus.wr_sdram_req), 32'd0);
      pulse_ack(1'b0, 1'b1);
      check("t4_rd_addr_512", 32'(bus.rd_base_addr), 32'd512);
      check("t4_rd_req_drop", 32'(bus.rd_sdram_req), 32'd0);
      step();
`ifdef ARB_RR_EN
      check("t4_rr_wr_next", 32'(bus.wr_sdram_req), 32'd1);
      check("t4_rr_rd_idle", 32'(bus.rd_sdram_req), 32'd0);
      // both acks: only the active write direction moves
      pulse_ack(1'b1, 1'b1);
      check("t5_sim_wr_addr", 32'(bus.wr_base_addr), 32'd512);
      check("t5_sim_rd_addr", 32'(bus.rd_base_addr), 32'd512);
`else
      check("t4_fixed_rd_next", 32'(bus.rd_sdram_req), 32'd1);
      check("t4_fixed_wr_idle", 32'(bus.wr_sdram_req), 32'd0);
      // both acks: only the active read direction moves
      pulse_ack(1'b1, 1'b1);
      check("t5_sim_wr_addr", 32'(bus.wr_base_addr), 32'd0);
      check("t5_sim_rd_addr", 32'(bus.rd_base_addr), 32'd1024);
`endif

      // Acks in IDLE are ignored
      wr_lvl = '0;
      rd_lvl = 10'd1000;
      step();
      pulse_ack(1'b1, 1'b1);
`ifdef ARB_RR_EN
      check("idle_ack_wr_addr", 32'(bus.wr_base_addr), 32'd512);
      check("idle_ack_rd_addr", 32'(bus.rd_base_addr), 32'd512);
`else
      check("idle_ack_wr_addr", 32'(bus.wr_base_addr), 32'd0);
      check("idle_ack_rd_addr", 32'(bus.rd_base_addr), 32'd1024);
`endif
      check("idle_ack_no_req", 32'(bus.wr_sdram_req | bus.rd_sdram_req), 32'd0);

      // 6: reset in the middle of a write request
      wr_lvl = 10'd512;
      wait_req(1'b0, 4, "t6_wr_req");
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_wr_req", 32'(bus.wr_sdram_req), 32'd0);
      check("t6_rst_rd_addr", 32'(bus.rd_base_addr), 32'd0);
      check("t6_rst_wr_addr", 32'(bus.wr_base_addr), 32'd0);
      check("t6_rst_fvalid", 32'(frame_valid), 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      check("t6_no_req_release", 32'(bus.wr_sdram_req), 32'd0);
      step();
      check("t6_req_after", 32'(bus.wr_sdram_req), 32'd1);
      check("t6_no_rd_after", 32'(bus.rd_sdram_req), 32'd0);

      check("excl_reqs", 32'(both_hi), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_sdram_port_arb
